ph_read_sched: RTL

- Host-side read scheduler for the four parasite-to-host registers (R1 FIFO, R2, R3, R4).
- Watches the per-register data-available flags and arbitrates round-robin between enabled registers. R1 can optionally be given fixed priority.
- Drives the host read strobe and one-hot register select, captures the selected byte, and presents it on a valid/ready stream with its channel tag.
- R3 two-byte mode is handled as a two-read burst.

---
 rtl/ph_read_sched_pkg.sv | 25 ++
 rtl/ph_read_sched_if.sv | 39 +++
 rtl/ph_read_sched_rr_arb.sv | 39 +++
 rtl/ph_read_sched.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ph_read_sched_pkg.sv
// Shared types and helpers for the parasite-to-host read scheduler.
package ph_sched_pkg;

  localparam int NUM_CH = 4;

  // Scheduler phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    RD   = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Register channel indices (R1 is the FIFO).
  localparam logic [1:0] CH_R1 = 2'd0;
  localparam logic [1:0] CH_R2 = 2'd1;
  localparam logic [1:0] CH_R3 = 2'd2;
  localparam logic [1:0] CH_R4 = 2'd3;

  // Channel index to one-hot register select.
  function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/ph_read_sched_if.sv
// Register-bus and output-stream bundle for the read scheduler.
interface ph_read_sched_if;

  // configuration
  logic [3:0] en_mask;
  logic       prio_r1;
  logic       one_byte_mode;
  // host register bus
  logic [3:0] h_data_available;
  logic       h_zero_bytes_available;
  logic [7:0] h_data;
  logic [3:0] h_selectData;
  logic       h_rd;
  // captured byte stream
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic       underrun;

  // Scheduler side.
  modport master (
    input  en_mask, prio_r1, one_byte_mode,
    input  h_data_available, h_zero_bytes_available, h_data,
    output h_selectData, h_rd,
    output out_valid, out_data, out_chan, underrun,
    input  out_ready
  );

  // Register file / consumer side.
  modport slave (
    output en_mask, prio_r1, one_byte_mode,
    output h_data_available, h_zero_bytes_available, h_data,
    input  h_selectData, h_rd,
    input  out_valid, out_data, out_chan, underrun,
    output out_ready
  );

endinterface

// File: rtl/ph_read_sched_rr_arb.sv
// Combinational 4-way round-robin picker with optional R1 override.
module ph_rr_arb
  import ph_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  input  logic              prio,
  output logic [1:0]        gnt,
  output logic              gnt_vld
);

  logic [NUM_CH-1:0] rot;   // req rotated so bit 0 is the pointer position
  logic [1:0]        off;   // offset of first request from the pointer

  // rotate request vector by the pointer; 2-bit cast gives the wrap
  for (genvar i = 0; i < NUM_CH; i++) begin : g_rot
    assign rot[i] = req[2'(i + int'(ptr))];
  end

  // first set bit of the rotated vector
  always_comb begin
    off = 2'd0;
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  // R1 override wins only when R1 is actually requesting
  always_comb begin
    gnt_vld = |req;
    if (prio && req[CH_R1]) gnt = CH_R1;
    else                    gnt = 2'(ptr + off);
  end

endmodule

// File: rtl/ph_read_sched.sv
// Host-side read scheduler: arbitrates among the four parasite-to-host
// registers, strobes the selected one, and streams the captured byte out.
module ph_read_sched
  import ph_sched_pkg::*;
#(
  parameter int HOLDOFF   = 2,
  parameter int HOLDOFF_W = 2
) (
  input  logic h_phi2,
  input  logic h_rst,
  ph_read_sched_if.master bus
);

  localparam logic [HOLDOFF_W-1:0] HOLD_LOAD = HOLDOFF_W'(HOLDOFF);

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            ptr_q,   ptr_d;
  logic [HOLDOFF_W-1:0]  hold_q,  hold_d;
  logic                  burst_q, burst_d;
  logic [NUM_CH-1:0]     sel_q,   sel_d;
  logic                  rd_q,    rd_d;
  logic                  vld_q,   vld_d;
  logic [7:0]            data_q,  data_d;
  logic [1:0]            chan_q,  chan_d;
  logic                  under_q, under_d;

  logic [NUM_CH-1:0]     elig;
  logic [1:0]            arb_gnt;
  logic                  arb_vld;
  logic                  burst_go;

  assign elig = bus.h_data_available & bus.en_mask;

  ph_rr_arb u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .prio    (bus.prio_r1),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld)
  );

  // second R3 byte is taken straight away when the FIFO still holds one
  assign burst_go = (grant_q == CH_R3) && !bus.one_byte_mode && !burst_q &&
                    !bus.h_zero_bytes_available;

  // next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    burst_d = burst_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    vld_d   = vld_q;
    data_d  = data_q;
    chan_d  = chan_q;
    under_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (arb_vld) begin
          grant_d = arb_gnt;
          sel_d   = onehot4(arb_gnt);
          state_d = SEL;
        end
      end
      SEL: begin
        // flag must still be up after the select has settled
        if (bus.h_data_available[grant_q]) begin
          rd_d    = 1'b1;
          state_d = RD;
        end else begin
          sel_d   = '0;
          under_d = 1'b1;
          burst_d = 1'b0;
          state_d = IDLE;
        end
      end
      RD: begin
        data_d  = bus.h_data;
        chan_d  = grant_q;
        vld_d   = 1'b1;
        rd_d    = 1'b0;
        sel_d   = '0;
        ptr_d   = 2'(grant_q + 2'd1);
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          vld_d = 1'b0;
          if (burst_go) begin
            burst_d = 1'b1;
            sel_d   = onehot4(CH_R3);
            state_d = SEL;
          end else begin
            burst_d = 1'b0;
            hold_d  = HOLD_LOAD;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge h_phi2) begin
    if (h_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      burst_q <= 1'b0;
      sel_q   <= '0;
      rd_q    <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      burst_q <= burst_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      under_q <= under_d;
    end
  end

  assign bus.h_selectData = sel_q;
  assign bus.h_rd         = rd_q;
  assign bus.out_valid    = vld_q;
  assign bus.out_data     = data_q;
  assign bus.out_chan     = chan_q;
  assign bus.underrun     = under_q;

endmodule
